// File: rtl/adsr_voice_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adsr_voice_alloc : shares a pool of adsr envelope generators among a       |
// |                    note-on/off stream, stealing a voice when none is free. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adsr_voice_alloc #(
   parameter int VOICES = 4,
   parameter int NOTE_W = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ev_valid,
   output logic                     ev_ready,
   input  logic                     ev_on,
   input  logic [NOTE_W-1:0]        ev_note,
   input  logic [VOICES-1:0]        env_zero,
   output logic [VOICES-1:0]        voice_trig,
   output logic [VOICES-1:0]        voice_kill,
   output logic [VOICES*NOTE_W-1:0] voice_note,
   output logic [7:0]               steal_cnt
);

   localparam int C_IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECIDE = 2'd1,
      S_KILL   = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic                     on_q, on_d;
   logic [NOTE_W-1:0]        note_q, note_d;
   logic [VOICES-1:0]        trig_q, trig_d;
   logic [VOICES-1:0]        kill_q, kill_d;
   logic [VOICES*NOTE_W-1:0] vnote_q, vnote_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [C_IDX_W-1:0]       ptr_q, ptr_d;
   logic [C_IDX_W-1:0]       victim_q, victim_d;

   logic [VOICES-1:0]        w_match, w_free, w_rel;
   logic                     w_free_any, w_rel_any;
   logic [C_IDX_W-1:0]       w_free_idx, w_rel_idx, w_vic, w_ptr_next;

   // Voice classification, only meaningful while the latched event is decided.
   always_comb begin
      w_match = '0;
      for (int v = 0; v < VOICES; v++) begin
         w_match[v] = trig_q[v] && (vnote_q[v*NOTE_W +: NOTE_W] == note_q);
      end
   end

   assign w_free     = ~trig_q & env_zero;
   assign w_rel      = ~trig_q & ~env_zero;
   assign w_free_any = |w_free;
   assign w_rel_any  = |w_rel;

   // Scanning downward leaves the lowest set index as the final winner.
   always_comb begin
      w_free_idx = '0;
      w_rel_idx  = '0;
      for (int v = VOICES - 1; v >= 0; v--) begin
         if (w_free[v]) w_free_idx = C_IDX_W'(v);
         if (w_rel[v])  w_rel_idx  = C_IDX_W'(v);
      end
   end

   assign w_vic      = w_rel_any ? w_rel_idx : ptr_q;
   assign w_ptr_next = (ptr_q == C_IDX_W'(VOICES - 1)) ? '0 : ptr_q + C_IDX_W'(1);

   always_comb begin
      state_d  = state_q;
      on_d     = on_q;
      note_d   = note_q;
      trig_d   = trig_q;
      kill_d   = kill_q;
      vnote_d  = vnote_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      victim_d = victim_q;
      ev_ready = (state_q == S_IDLE) && !rst;

      case (state_q)
         S_IDLE: begin
            if (ev_valid && (state_q == S_IDLE) && !rst) begin
               on_d    = ev_on;
               note_d  = ev_note;
               state_d = S_DECIDE;
            end
         end

         S_DECIDE: begin
            state_d = S_IDLE;
            if (!on_q) begin
               trig_d = trig_q & ~w_match;
            end else if (!(|w_match)) begin
               if (w_free_any) begin
                  trig_d[w_free_idx] = 1'b1;
                  for (int v = 0; v < VOICES; v++) begin
                     if (C_IDX_W'(v) == w_free_idx) vnote_d[v*NOTE_W +: NOTE_W] = note_q;
                  end
               end else begin
                  kill_d          = '0;
                  kill_d[w_vic]   = 1'b1;
                  trig_d[w_vic]   = 1'b0;
                  victim_d        = w_vic;
                  cnt_d           = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                  if (!w_rel_any) ptr_d = w_ptr_next;
                  state_d         = S_KILL;
               end
            end
         end

         // The victim's adsr is held in reset this cycle, so it re-triggers from idle.
         S_KILL: begin
            kill_d           = '0;
            trig_d[victim_q] = 1'b1;
            for (int v = 0; v < VOICES; v++) begin
               if (C_IDX_W'(v) == victim_q) vnote_d[v*NOTE_W +: NOTE_W] = note_q;
            end
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         on_q     <= 1'b0;
         note_q   <= '0;
         trig_q   <= '0;
         kill_q   <= '0;
         vnote_q  <= '0;
         cnt_q    <= '0;
         ptr_q    <= '0;
         victim_q <= '0;
      end else begin
         state_q  <= state_d;
         on_q     <= on_d;
         note_q   <= note_d;
         trig_q   <= trig_d;
         kill_q   <= kill_d;
         vnote_q  <= vnote_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         victim_q <= victim_d;
      end
   end

   assign voice_trig = trig_q;
   assign voice_kill = kill_q;
   assign voice_note = vnote_q;
   assign steal_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adsr_voice_alloc.sv
`default_nettype none
// tb_adsr_voice_alloc : directed and randomized event streams checked against an
// array model of the allocation rules, with a behavioural adsr driving env_zero.
module tb_adsr_voice_alloc;
   localparam int VOICES = 4;
   localparam int NOTE_W = 7;
   localparam int FW     = 2*VOICES + VOICES*NOTE_W + 9;

   logic                     clk = 1'b0;
   logic                     rst, ev_valid, ev_ready, ev_on;
   logic [NOTE_W-1:0]        ev_note;
   logic [VOICES-1:0]        env_zero, voice_trig, voice_kill;
   logic [VOICES*NOTE_W-1:0] voice_note;
   logic [7:0]               steal_cnt;

   int vectors     = 0;
   int miscompares = 0;

   adsr_voice_alloc #(.VOICES(VOICES), .NOTE_W(NOTE_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_on      (ev_on),
      .ev_note    (ev_note),
      .env_zero   (env_zero),
      .voice_trig (voice_trig),
      .voice_kill (voice_kill),
      .voice_note (voice_note),
      .steal_cnt  (steal_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural adsr per voice: ai=0x40, di=0x10, s=0x80, ri=0x08.
   logic [7:0] env    [VOICES];
   logic       attack [VOICES];
   always @(posedge clk) begin
      for (int v = 0; v < VOICES; v++) begin
         if (rst || voice_kill[v]) begin
            env[v]    <= 8'h00;
            attack[v] <= 1'b1;
         end else if (voice_trig[v]) begin
            if (attack[v]) begin
               if (env[v] >= 8'hBF) begin
                  env[v]    <= 8'hFF;
                  attack[v] <= 1'b0;
               end else begin
                  env[v] <= env[v] + 8'h40;
               end
            end else begin
               env[v] <= (env[v] >= 8'h90) ? env[v] - 8'h10 : 8'h80;
            end
         end else begin
            attack[v] <= 1'b1;
            env[v]    <= (env[v] > 8'h08) ? env[v] - 8'h08 : 8'h00;
         end
      end
   end

   always_comb begin
      env_zero = '0;
      for (int v = 0; v < VOICES; v++) env_zero[v] = (env[v] == 8'h00);
   end

   // Reference model: what each voice plays and whether it is keyed.
   logic              m_trig [VOICES];
   int                m_note [VOICES];
   int                m_cnt, m_ptr;
   logic [VOICES-1:0] e_trig2, e_kill2;
   logic              e_rdy2;
   logic              o_rdy1, o_rdy2;
   logic [VOICES-1:0] o_trig2, o_kill2;

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_trig[v] = 1'b0;
         m_note[v] = 0;
      end
      m_cnt = 0;
      m_ptr = 0;
   endtask

   function automatic logic [VOICES-1:0] pack_trig();
      logic [VOICES-1:0] t;
      for (int v = 0; v < VOICES; v++) t[v] = m_trig[v];
      return t;
   endfunction

   function automatic logic [FW-1:0] exp_final();
      logic [VOICES*NOTE_W-1:0] nv;
      for (int v = 0; v < VOICES; v++) nv[v*NOTE_W +: NOTE_W] = NOTE_W'(m_note[v]);
      return {pack_trig(), {VOICES{1'b0}}, nv, 8'(m_cnt), 1'b1};
   endfunction

   task automatic model_apply(input logic on, input int note, input logic [VOICES-1:0] ez);
      int hit, fr, rl, vic;
      e_kill2 = '0;
      e_rdy2  = 1'b1;
      hit = 0; fr = -1; rl = -1;
      for (int v = 0; v < VOICES; v++) begin
         if (m_trig[v] && m_note[v] == note) hit = 1;
         if (!m_trig[v] && ez[v] && fr < 0) fr = v;
         if (!m_trig[v] && !ez[v] && rl < 0) rl = v;
      end
      if (!on) begin
         for (int v = 0; v < VOICES; v++)
            if (m_trig[v] && m_note[v] == note) m_trig[v] = 1'b0;
         e_trig2 = pack_trig();
      end else if (hit != 0) begin
         e_trig2 = pack_trig();
      end else if (fr >= 0) begin
         m_trig[fr] = 1'b1;
         m_note[fr] = note;
         e_trig2    = pack_trig();
      end else begin
         if (rl >= 0) vic = rl;
         else begin
            vic   = m_ptr;
            m_ptr = (m_ptr + 1) % VOICES;
         end
         m_trig[vic]  = 1'b0;
         e_trig2      = pack_trig();
         e_kill2[vic] = 1'b1;
         e_rdy2       = 1'b0;
         m_cnt        = (m_cnt < 255) ? m_cnt + 1 : 255;
         m_trig[vic]  = 1'b1;
         m_note[vic]  = note;
      end
   endtask

   // Sends one event and stops at the falling edge where the allocator is idle again.
   task automatic do_event(input logic on, input int note);
      int guard = 0;
      while (ev_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (ev_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_timeout: ev_ready=%b required 1", ev_ready);
      end
      ev_valid = 1'b1;
      ev_on    = on;
      ev_note  = NOTE_W'(note);
      @(negedge clk);
      ev_valid = 1'b0;
      o_rdy1   = ev_ready;
      model_apply(on, note, env_zero);
      @(negedge clk);
      o_rdy2  = ev_ready;
      o_trig2 = voice_trig;
      o_kill2 = voice_kill;
      if (!e_rdy2) @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({ev_ready, voice_trig, voice_kill, voice_note, steal_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs c%0d: got rdy=%b trig=%h kill=%h note=%h cnt=%0d, want all 0",
                     c, ev_ready, voice_trig, voice_kill, voice_note, steal_cnt);
         end
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (ev_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b want 1", ev_ready);
      end
   endtask

   task automatic test_fill();
      int notes [4] = '{60, 62, 64, 67};
      for (int i = 0; i < 4; i++) begin
         do_event(1'b1, notes[i]);
         vectors++;
         if (o_rdy1 !== 1'b0 || o_rdy2 !== e_rdy2) begin miscompares++;
            $display("FAIL fill_ready ev%0d: got c1=%b c2=%b want c1=0 c2=%b", i, o_rdy1, o_rdy2, e_rdy2); end
         vectors++;
         if (o_trig2 !== e_trig2) begin miscompares++;
            $display("FAIL fill_trig_c2 ev%0d: got %b want %b", i, o_trig2, e_trig2); end
         vectors++;
         if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
            $display("FAIL fill_state ev%0d: got %h want %h", i, {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
      end
   endtask

   task automatic test_release_steal();
      int ons   [4] = '{0, 1, 0, 1};
      int notes [4] = '{62, 70, 70, 71};
      int guard;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            guard = 0;
            while (env_zero[1] !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
            vectors++;
            if (env_zero[1] !== 1'b1) begin miscompares++;
               $display("FAIL release_timeout: env_zero[1]=%b want 1", env_zero[1]); end
         end
         do_event(ons[i] != 0, notes[i]);
         vectors++;
         if (o_rdy1 !== 1'b0 || o_rdy2 !== e_rdy2) begin miscompares++;
            $display("FAIL relsteal_ready ev%0d: got c1=%b c2=%b want c1=0 c2=%b", i, o_rdy1, o_rdy2, e_rdy2); end
         vectors++;
         if (o_trig2 !== e_trig2 || o_kill2 !== e_kill2) begin miscompares++;
            $display("FAIL relsteal_c2 ev%0d: got trig=%b kill=%b want trig=%b kill=%b", i, o_trig2, o_kill2, e_trig2, e_kill2); end
         vectors++;
         if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
            $display("FAIL relsteal_state ev%0d: got %h want %h", i, {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
      end
   endtask

   task automatic test_round_robin();
      int notes [2] = '{72, 73};
      for (int i = 0; i < 2; i++) begin
         do_event(1'b1, notes[i]);
         vectors++;
         if (o_rdy1 !== 1'b0 || o_rdy2 !== e_rdy2) begin miscompares++;
            $display("FAIL rr_ready ev%0d: got c1=%b c2=%b want c1=0 c2=%b", i, o_rdy1, o_rdy2, e_rdy2); end
         vectors++;
         if (o_trig2 !== e_trig2 || o_kill2 !== e_kill2) begin miscompares++;
            $display("FAIL rr_c2 ev%0d: got trig=%b kill=%b want trig=%b kill=%b", i, o_trig2, o_kill2, e_trig2, e_kill2); end
         vectors++;
         if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
            $display("FAIL rr_state ev%0d: got %h want %h", i, {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
      end
   endtask

   task automatic test_duplicates();
      int ons   [3] = '{1, 0, 1};
      int notes [3] = '{64, 99, 73};
      for (int i = 0; i < 3; i++) begin
         do_event(ons[i] != 0, notes[i]);
         vectors++;
         if (o_rdy1 !== 1'b0 || o_rdy2 !== e_rdy2) begin miscompares++;
            $display("FAIL dup_ready ev%0d: got c1=%b c2=%b want c1=0 c2=%b", i, o_rdy1, o_rdy2, e_rdy2); end
         vectors++;
         if (o_trig2 !== e_trig2 || o_kill2 !== e_kill2) begin miscompares++;
            $display("FAIL dup_c2 ev%0d: got trig=%b kill=%b want trig=%b kill=%b", i, o_trig2, o_kill2, e_trig2, e_kill2); end
         vectors++;
         if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
            $display("FAIL dup_state ev%0d: got %h want %h", i, {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
      end
   endtask

   task automatic test_random();
      logic on;
      int   note;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 10)) @(negedge clk);
         on   = ($urandom_range(0, 2) != 0);
         note = 60 + int'($urandom_range(0, 7));
         do_event(on, note);
         vectors++;
         if (o_rdy1 !== 1'b0 || o_rdy2 !== e_rdy2) begin miscompares++;
            $display("FAIL rand_ready ev%0d: got c1=%b c2=%b want c1=0 c2=%b", i, o_rdy1, o_rdy2, e_rdy2); end
         vectors++;
         if (o_trig2 !== e_trig2 || o_kill2 !== e_kill2) begin miscompares++;
            $display("FAIL rand_c2 ev%0d: got trig=%b kill=%b want trig=%b kill=%b", i, o_trig2, o_kill2, e_trig2, e_kill2); end
         vectors++;
         if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
            $display("FAIL rand_state ev%0d: got %h want %h", i, {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         do_event(1'b1, (i * 5) % 128);
         vectors++;
         if (o_trig2 !== e_trig2 || o_kill2 !== e_kill2 || o_rdy2 !== e_rdy2) begin miscompares++;
            $display("FAIL sat_c2 ev%0d: got trig=%b kill=%b rdy=%b want trig=%b kill=%b rdy=%b",
                     i, o_trig2, o_kill2, o_rdy2, e_trig2, e_kill2, e_rdy2); end
         vectors++;
         if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
            $display("FAIL sat_state ev%0d: got %h want %h", i, {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
      end
      vectors++;
      if (steal_cnt !== 8'hFF) begin miscompares++;
         $display("FAIL sat_count: got %0d want 255", steal_cnt); end
   endtask

   task automatic test_reset_mid_steal();
      int n = 0;
      int guard = 0;
      for (int k = 0; k < 128; k++) begin
         for (int v = 0; v < VOICES; v++) if (m_trig[v] && m_note[v] == n) n = n + 1;
      end
      n = n % 128;
      while (ev_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = NOTE_W'(n);
      @(negedge clk);
      ev_valid = 1'b0;
      model_apply(1'b1, n, env_zero);
      @(negedge clk);
      vectors++;
      if (voice_kill !== e_kill2) begin miscompares++;
         $display("FAIL midsteal_kill: got %b want %b", voice_kill, e_kill2); end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({ev_ready, voice_trig, voice_kill, voice_note, steal_cnt} !== '0) begin miscompares++;
         $display("FAIL midsteal_reset: got rdy=%b trig=%b kill=%b note=%h cnt=%0d want all 0",
                  ev_ready, voice_trig, voice_kill, voice_note, steal_cnt); end
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      do_event(1'b1, 64);
      vectors++;
      if ({voice_trig, voice_kill, voice_note, steal_cnt, ev_ready} !== exp_final()) begin miscompares++;
         $display("FAIL post_reset_state: got %h want %h", {voice_trig, voice_kill, voice_note, steal_cnt, ev_ready}, exp_final()); end
   endtask

   initial begin
      rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;
      test_reset();
      test_fill();
      test_release_steal();
      test_round_robin();
      test_duplicates();
      test_random();
      test_saturation();
      test_reset_mid_steal();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
